cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor; successor to the fixed 16-bit combinational CLA.
- Carries propagate correctly between look-ahead groups.
- Adds a subtract mode, status flags and valid/ready elastic handshakes on both sides.
- Sits as the ALU add/sub datapath unit, stallable by downstream logic.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per look-ahead group; generate/propagate computed per group.
- PIPE, 2, number of register stages (1..WIDTH/GROUP); also the latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept an operand set this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  0 = add, 1 = subtract mode
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB
- ovf  out  1  signed (two's complement) overflow
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

Behaviour:
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + cin. The caller drives cin=1 for a true a-b. cout=1 means no borrow.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff = sub ? ~b : b.
  - zero and neg are derived from the final sum.
- Carry structure:
  - Within a group, carries use look-ahead from group G/P.
  - The group carry-in is the true carry-out of the previous group, never the global cin (except group 0).
  - Group carries are resolved across PIPE stages. The split of groups per stage is implementation choice, but results must be bit-exact for any legal PIPE.
- Transfers:
  - Input transfer occurs on a rising edge where in_valid && in_ready.
  - Output transfer occurs where out_valid && out_ready.
  - All operands, cin and sub are captured at input transfer. Later input changes do not affect in-flight ops.
- Pipeline:
  - Each stage holds one valid bit plus data.
  - Stage k loads when it is empty or its contents move on this edge.
  - in_ready = stage 0 can load. This is combinational from out_ready through the full-stage chain; no skid buffer is required.
- Latency and throughput:
  - An op accepted at edge N appears with out_valid=1 immediately after edge N+PIPE-1, provided there is no stall.
  - PIPE=1 means a registered output one edge after accept.
  - Throughput is 1 op/cycle with out_ready held high.
- Backpressure:
  - While out_valid && !out_ready, the output registers (sum/cout/ovf/zero/neg) and out_valid hold stable.
  - Upstream stages fill, then in_ready drops to 0. No op is lost or duplicated.
  - Ordering is strictly FIFO.
- Simultaneous events: in a full pipeline, when out_ready=1 and in_valid=1 in the same cycle, the output transfers and the new input is accepted on the same edge.
- Reset:
  - Synchronous. At an edge with rst=1, all valid bits clear, out_valid=0, and sum/cout/ovf/zero/neg=0.
  - in_ready=0 while rst=1; in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-operation discards all in-flight ops; nothing is emitted afterwards for them.
- Wrap-around: results are modulo 2^WIDTH, with overflow indicated only via cout/ovf. There is no saturation.

Test Plan:
- WIDTH=16, PIPE=2, add, out_ready=1: a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0, zero=0, out_valid exactly 1 edge after accept edge + 1 (2-cycle latency). Covers inter-group carry.
- Full ripple: a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, zero=1, ovf=0.
- Subtract and overflow cases:
  - sub=1, cin=1: a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1, neg=0.
  - sub=1, cin=1: a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, neg=1.
  - sub=0: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
- Backpressure: stream 4 back-to-back ops (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 5 cycles.
  - in_ready falls after PIPE ops are held.
  - Outputs stay at 0x0002.
  - Releasing out_ready yields 0x0002, 0x0004, 0x0006, 0x0008 in order on consecutive cycles.
- Reset mid-flight: accept 0x1234+0x1111, assert rst one cycle later -> out_valid stays 0 and that result never appears. The first post-reset op 0x0001+0x0001 returns 0x0002.
- Parametrisation: WIDTH=32, GROUP=8, PIPE=4, a=0x0000FFFF, b=0x00000001 -> sum=0x00010000, 4-cycle latency. Random 1000 ops vs. a behavioural model with out_ready randomly toggled, compared bit-exact including flags.

Source files
------------

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bundle for the pipelined CLA add/sub unit.
// Both sides are elastic valid/ready ports on the same clock.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-look-ahead adder/subtractor with status flags.
// Look-ahead groups are spread over PIPE register stages; carries chain group to group.
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4,
  parameter int PIPE  = 2
) (
  input logic              clk,
  input logic              rst,
  cla_addsub_pipe_if.slave bus
);
  localparam int NG = WIDTH / GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;  // effective operand, already inverted in subtract mode
    logic [WIDTH-1:0] s;  // sum bits of the groups resolved so far
    logic             c;  // carry into the first unresolved group
  } stage_t;

  stage_t          st_q   [PIPE];
  stage_t          st_src [PIPE];
  stage_t          st_n   [PIPE];
  logic [PIPE-1:0] v_q;
  logic [PIPE-1:0] v_src;
  logic [PIPE-1:0] rdy;
  logic            ovf_q, zero_q, neg_q;
  logic            ovf_n, zero_n, neg_n;

  // One look-ahead group: returns {carry_out, sum}. Every carry is a flat
  // sum-of-products of g/p and the group carry-in rather than a ripple.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] ga,
                                               input logic [GROUP-1:0] gb,
                                               input logic             gc);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             acc;
    logic             pp;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = '0;
    c[0] = gc;
    for (int i = 0; i < GROUP; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & gc);
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  always_comb begin : feed
    v_src     = '0;
    st_src[0] = '{a: bus.a, b: (bus.sub ? ~bus.b : bus.b), s: '0, c: bus.cin};
    v_src[0]  = bus.in_valid;
    for (int k = 1; k < PIPE; k++) begin
      st_src[k] = st_q[k-1];
      v_src[k]  = v_q[k-1];
    end
  end

  // Stage k resolves groups [k*NG/PIPE, (k+1)*NG/PIPE); each stage owns at least one group.
  always_comb begin : resolve
    logic [WIDTH-1:0] s;
    logic             c;
    logic [GROUP:0]   r;
    s = '0;
    c = 1'b0;
    r = '0;
    for (int k = 0; k < PIPE; k++) begin
      s = st_src[k].s;
      c = st_src[k].c;
      for (int gi = 0; gi < NG; gi++) begin
        if (gi >= (k * NG) / PIPE && gi < ((k + 1) * NG) / PIPE) begin
          r = cla_group(st_src[k].a[gi*GROUP +: GROUP], st_src[k].b[gi*GROUP +: GROUP], c);
          s[gi*GROUP +: GROUP] = r[GROUP-1:0];
          c = r[GROUP];
        end
      end
      st_n[k] = '{a: st_src[k].a, b: st_src[k].b, s: s, c: c};
    end
  end

  assign ovf_n  = (st_n[PIPE-1].a[WIDTH-1] == st_n[PIPE-1].b[WIDTH-1]) &&
                  (st_n[PIPE-1].s[WIDTH-1] != st_n[PIPE-1].a[WIDTH-1]);
  assign zero_n = (st_n[PIPE-1].s == '0);
  assign neg_n  = st_n[PIPE-1].s[WIDTH-1];

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side. A stage can load when it is empty or its contents leave on
  // the same edge, so ready chains back combinationally from out_ready.
  always_comb begin : ready_chain
    logic r;
    rdy = '0;
    r   = bus.out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || r;
      r      = rdy[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      for (int k = 0; k < PIPE; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        if (rdy[k]) begin
          v_q[k] <= v_src[k];
          if (v_src[k]) st_q[k] <= st_n[k];
        end
      end
      if (rdy[PIPE-1] && v_src[PIPE-1]) begin
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
        neg_q  <= neg_n;
      end
    end
  end

  assign bus.in_ready  = rdy[0] && !rst;
  assign bus.out_valid = v_q[PIPE-1];
  assign bus.sum       = st_q[PIPE-1].s;
  assign bus.cout      = st_q[PIPE-1].c;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: a 16/4/2 and a 32/8/4 instance checked against
// a behavioural add/sub model through per-instance expected queues.
module tb_cla_addsub_pipe;
  localparam int EW = 36;  // {sum[31:0], cout, ovf, zero, neg}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   acc16 = 0;
  int   acc32 = 0;
  bit   done16 = 0;
  bit   done32 = 0;
  bit   stall16 = 0;
  bit   stall32 = 0;
  logic [EW-1:0] held16, held32;
  logic [EW-1:0] exp16_q[$];
  logic [EW-1:0] exp32_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cla_addsub_pipe_if #(.WIDTH(16)) bus16();
  cla_addsub_pipe_if #(.WIDTH(32)) bus32();

  cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .PIPE(2)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  cla_addsub_pipe #(.WIDTH(32), .GROUP(8), .PIPE(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  logic [EW-1:0] obs16, obs32;
  assign obs16 = {16'h0, bus16.sum, bus16.cout, bus16.ovf, bus16.zero, bus16.neg};
  assign obs32 = {bus32.sum, bus32.cout, bus32.ovf, bus32.zero, bus32.neg};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [31:0] s, input logic c, o, z, n);
    return {s, c, o, z, n};
  endfunction

  function automatic logic [EW-1:0] model(input int w, input logic [31:0] a, b, input logic cin, sub);
    logic [32:0] full;
    logic [31:0] m, be, s;
    logic        c, o;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    be   = (sub ? ~b : b) & m;
    full = {1'b0, a & m} + {1'b0, be} + {32'h0, cin};
    s    = full[31:0] & m;
    c    = full[w];
    o    = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    return {s, c, o, (s == 32'h0), s[w-1]};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [15:0] a, b, input logic cin, sub, input logic [EW-1:0] exp);
    int n = 0;
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.in_valid = 1'b1;
    @(negedge clk);
    while (!bus16.in_ready && n < 200) begin @(negedge clk); n++; end
    if (bus16.in_ready) begin
      exp16_q.push_back(exp);
      acc16 = cyc + 1;
    end else check("send16_timeout", 64'(bus16.in_ready), 64'(1));
    sync();
    bus16.in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, b, input logic cin, sub, input logic [EW-1:0] exp);
    int n = 0;
    bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.sub = sub; bus32.in_valid = 1'b1;
    @(negedge clk);
    while (!bus32.in_ready && n < 200) begin @(negedge clk); n++; end
    if (bus32.in_ready) begin
      exp32_q.push_back(exp);
      acc32 = cyc + 1;
    end else check("send32_timeout", 64'(bus32.in_ready), 64'(1));
    sync();
    bus32.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp16_q.size() != 0 || exp32_q.size() != 0) && n < 1000) begin @(negedge clk); n++; end
    check("drain16", 64'(exp16_q.size()), 64'(0));
    check("drain32", 64'(exp32_q.size()), 64'(0));
    sync();
  endtask

  // Output scoreboards plus a hold check: a stalled output must not change.
  always @(negedge clk) begin
    if (rst) stall16 = 0;
    else begin
      if (stall16) check("hold16", {28'h0, bus16.out_valid, obs16}, {28'h0, 1'b1, held16});
      if (bus16.out_valid && bus16.out_ready) begin
        if (exp16_q.size() == 0) check("spurious16", 64'(exp16_q.size()), 64'(1));
        else check("res16", 64'(obs16), 64'(exp16_q.pop_front()));
      end
      stall16 = bus16.out_valid && !bus16.out_ready;
      held16  = obs16;
    end
  end

  always @(negedge clk) begin
    if (rst) stall32 = 0;
    else begin
      if (stall32) check("hold32", {28'h0, bus32.out_valid, obs32}, {28'h0, 1'b1, held32});
      if (bus32.out_valid && bus32.out_ready) begin
        if (exp32_q.size() == 0) check("spurious32", 64'(exp32_q.size()), 64'(1));
        else check("res32", 64'(obs32), 64'(exp32_q.pop_front()));
      end
      stall32 = bus32.out_valid && !bus32.out_ready;
      held32  = obs32;
    end
  end

  task automatic rand16(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a, b;
      logic        cin, sub;
      repeat ($urandom_range(0, 2)) sync();
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      send16(a, b, cin, sub, model(16, {16'h0, a}, {16'h0, b}, cin, sub));
    end
    done16 = 1;
  endtask

  task automatic rand32(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, b;
      logic        cin, sub;
      repeat ($urandom_range(0, 1)) sync();
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'hFFFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = ~a;
        default: b = $urandom;
      endcase
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      send32(a, b, cin, sub, model(32, a, b, cin, sub));
    end
    done32 = 1;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus16.in_valid = 0; bus16.a = '0; bus16.b = '0; bus16.cin = 0; bus16.sub = 0; bus16.out_ready = 1;
    bus32.in_valid = 0; bus32.a = '0; bus32.b = '0; bus32.cin = 0; bus32.sub = 0; bus32.out_ready = 1;
    rst = 1;
    repeat (3) sync();
    @(negedge clk);
    check("rst_in_ready16", 64'(bus16.in_ready), 64'(0));
    check("rst_out_valid16", 64'(bus16.out_valid), 64'(0));
    check("rst_outputs16", 64'(obs16), 64'(0));
    check("rst_in_ready32", 64'(bus32.in_ready), 64'(0));
    check("rst_out_valid32", 64'(bus32.out_valid), 64'(0));
    check("rst_outputs32", 64'(obs32), 64'(0));
    sync();
    rst = 0;
    @(negedge clk);
    check("post_rst_in_ready16", 64'(bus16.in_ready), 64'(1));
    check("post_rst_in_ready32", 64'(bus32.in_ready), 64'(1));
    sync();

    // Inter-group carry and two-edge latency on the 16-bit instance.
    send16(16'h00FF, 16'h0001, 0, 0, pk(32'h0100, 0, 0, 0, 0));
    begin
      int n = 0;
      @(negedge clk);
      while (!bus16.out_valid && n < 20) begin @(negedge clk); n++; end
      check("lat16", 64'(cyc - acc16), 64'(1));
    end
    sync();
    send16(16'hFFFF, 16'h0000, 1, 0, pk(32'h0000, 1, 0, 1, 0));
    send16(16'h8000, 16'h0001, 1, 1, pk(32'h7FFF, 1, 1, 0, 0));
    send16(16'h0003, 16'h0005, 1, 1, pk(32'hFFFE, 0, 0, 0, 1));
    send16(16'h7FFF, 16'h0001, 0, 0, pk(32'h8000, 0, 1, 0, 1));
    drain();

    // Four back-to-back ops against a five-cycle stall.
    bus16.out_ready = 0;
    fork
      begin
        send16(16'd1, 16'd1, 0, 0, pk(32'h2, 0, 0, 0, 0));
        send16(16'd2, 16'd2, 0, 0, pk(32'h4, 0, 0, 0, 0));
        send16(16'd3, 16'd3, 0, 0, pk(32'h6, 0, 0, 0, 0));
        send16(16'd4, 16'd4, 0, 0, pk(32'h8, 0, 0, 0, 0));
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", 64'(bus16.in_ready), 64'(0));
        check("bp_out_valid", 64'(bus16.out_valid), 64'(1));
        check("bp_hold_sum", 64'(bus16.sum), 64'(16'h0002));
        sync();
        bus16.out_ready = 1;
        repeat (4) begin
          @(negedge clk);
          check("bp_stream", 64'(bus16.out_valid && bus16.out_ready), 64'(1));
        end
      end
    join
    drain();

    // Reset one cycle after accepting an op: that result must never appear.
    send16(16'h1234, 16'h1111, 0, 0, pk(32'h2345, 0, 0, 0, 0));
    rst = 1;
    exp16_q.delete();
    @(negedge clk);
    check("midrst_in_ready", 64'(bus16.in_ready), 64'(0));
    sync();
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_flush", 64'(bus16.out_valid), 64'(0));
    end
    sync();
    send16(16'h0001, 16'h0001, 0, 0, pk(32'h0002, 0, 0, 0, 0));
    drain();

    // Wide instance: carry across an 8-bit group boundary, four-edge latency.
    send32(32'h0000_FFFF, 32'h0000_0001, 0, 0, pk(32'h0001_0000, 0, 0, 0, 0));
    begin
      int n = 0;
      @(negedge clk);
      while (!bus32.out_valid && n < 20) begin @(negedge clk); n++; end
      check("lat32", 64'(cyc - acc32), 64'(3));
    end
    sync();
    drain();

    // Random traffic with random backpressure on both instances.
    fork
      rand16(300);
      rand32(1000);
      begin
        while (!done16) begin bus16.out_ready = ($urandom_range(0, 3) != 0); sync(); end
        bus16.out_ready = 1;
      end
      begin
        while (!done32) begin bus32.out_ready = ($urandom_range(0, 3) != 0); sync(); end
        bus32.out_ready = 1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
